// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder tree: level count, per-level operand count and width.
package pipe_adder_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = n - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >> 32'sd1;
        end
        return r;
    endfunction

    function automatic int level_count(input int n);
        return clog2(n);
    endfunction

    // Each tree level is one bit wider than the one feeding it.
    function automatic int level_width(input int w, input int lvl);
        return w + lvl;
    endfunction

    // Operands left after lvl pairwise reductions (odd leftovers pass through).
    function automatic int level_ops(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 32'sd0; i < lvl; i++) begin
            c = (c + 32'sd1) / 32'sd2;
        end
        return c;
    endfunction

    function automatic int min_int(input int a, input int b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One adder-tree level: pairwise adders, odd-operand passthrough, data register, valid bit
// and the per-stage ready term.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int NI = 3,
    parameter int WI = 10,
    parameter int WO = 11
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        up_valid,
    input  logic [NI*WI-1:0]                            up_data,
    output logic                                        up_ready,
    output logic                                        dn_valid,
    output logic [((NI + 32'sd1) / 32'sd2)*WO-1:0]      dn_data,
    input  logic                                        dn_ready
);

    localparam int NO = (NI + 32'sd1) / 32'sd2;

    logic [NO*WO-1:0] sum_s;
    logic [NO*WO-1:0] data_r;
    logic             v_r;

    for (genvar j = 0; j < NO; j++) begin : gen_op
        if (2 * j + 1 < NI) begin : g_pair
            assign sum_s[j*WO +: WO] = WO'(up_data[2*j*WI +: WI]) + WO'(up_data[(2*j+1)*WI +: WI]);
        end else begin : g_pass
            assign sum_s[j*WO +: WO] = WO'(up_data[2*j*WI +: WI]);
        end
    end

    // An empty stage, or one whose contents leave this cycle, can take new data.
    assign up_ready = !v_r || dn_ready;
    assign dn_valid = v_r;
    assign dn_data  = data_r;

    // Level register: data only moves on a real transfer so it holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r    <= 1'b0;
            data_r <= '0;
        end else if (up_ready) begin
            v_r <= up_valid;
            if (up_valid) begin
                data_r <= sum_s;
            end
        end
    end

endmodule

// File: rtl/pipe_adder_tree.sv
// Pipelined unsigned adder tree with valid/ready on both sides; latency clog2(N_IN)+1.
// Define PIPE_ADDER_SAT_EN to saturate (and flag out_ovf) instead of truncating a too-wide sum.
module pipe_adder_tree
    import pipe_adder_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int W     = 10,
    parameter int OUT_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN*W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_sum,
    output logic                out_ovf
);

    localparam int L     = level_count(N_IN);
    localparam int SUM_W = W + clog2(N_IN);

    logic [L+1:0]       rdy_s;
    logic [L:0]         vld_s;
    logic               v0_r;
    logic [N_IN*W-1:0]  d0_r;
    logic [SUM_W-1:0]   full_s;

    assign rdy_s[L+1] = out_ready;
    assign rdy_s[0]   = !v0_r || rdy_s[1];
    assign vld_s[0]   = v0_r;
    assign in_ready   = rdy_s[0];
    assign out_valid  = vld_s[L];

    // Input register S0; operands are captured only on an accepted vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0;
            d0_r <= '0;
        end else if (rdy_s[0]) begin
            v0_r <= in_valid;
            if (in_valid) begin
                d0_r <= in_data;
            end
        end
    end

    for (genvar k = 1; k <= L; k++) begin : gen_lvl
        localparam int NI = level_ops(N_IN, k - 1);
        localparam int WI = min_int(level_width(W, k - 1), SUM_W);
        localparam int NO = level_ops(N_IN, k);
        localparam int WO = min_int(level_width(W, k), SUM_W);

        logic [NI*WI-1:0] din_s;
        logic [NO*WO-1:0] data_s;

        if (k == 1) begin : g_first
            assign din_s = d0_r;
        end else begin : g_rest
            assign din_s = gen_lvl[k-1].data_s;
        end

        pipe_adder_stage #(
            .NI (NI),
            .WI (WI),
            .WO (WO)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld_s[k-1]),
            .up_data  (din_s),
            .up_ready (rdy_s[k]),
            .dn_valid (vld_s[k]),
            .dn_data  (data_s),
            .dn_ready (rdy_s[k+1])
        );
    end

    assign full_s = gen_lvl[L].data_s;

    // Output shaping works straight off the last level register, so it holds under backpressure.
    if (OUT_W >= SUM_W) begin : g_wide
        assign out_sum = OUT_W'(full_s);
        assign out_ovf = 1'b0;
    end else begin : g_narrow
`ifdef PIPE_ADDER_SAT_EN
        logic ovf_s;
        assign ovf_s   = |full_s[SUM_W-1:OUT_W];
        assign out_ovf = ovf_s;
        // Clamp to the largest representable value when the upper bits are in use.
        always_comb begin
            if (ovf_s) begin
                out_sum = {OUT_W{1'b1}};
            end else begin
                out_sum = full_s[OUT_W-1:0];
            end
        end
`else
        assign out_sum = full_s[OUT_W-1:0];
        assign out_ovf = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Randomised bench for pipe_adder_tree: a 3x10 instance under random backpressure and a
// 5x8 instance (odd passthrough, 10-bit output) at full rate, both against queue models.
module tb_pipe_adder_tree;

    localparam int A_N = 3, A_W = 10, A_OW = 12, A_L = 2;
    localparam int B_N = 5, B_W = 8,  B_OW = 10, B_L = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [A_N*A_W-1:0]   a_in_data;
    logic [A_OW-1:0]      a_out_sum;
    logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [B_N*B_W-1:0]   b_in_data;
    logic [B_OW-1:0]      b_out_sum;

    pipe_adder_tree #(.N_IN(A_N), .W(A_W), .OUT_W(A_OW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf));

    pipe_adder_tree #(.N_IN(B_N), .W(B_W), .OUT_W(B_OW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_stall = -1;
    int a_q[$], a_t[$], b_q[$], b_t[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int vsum(input logic [63:0] d, input int n, input int w);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'((d >> (k * w)) & ((64'd1 << w) - 64'd1));
        return s;
    endfunction

    function automatic int exp_sum(input int full, input int ow);
        int mx = (1 << ow) - 1;
        if (full > mx) begin
`ifdef PIPE_ADDER_SAT_EN
            return mx;
`else
            return full % (mx + 1);
`endif
        end
        return full;
    endfunction

    function automatic int exp_ovf(input int full, input int ow);
`ifdef PIPE_ADDER_SAT_EN
        return (full > (1 << ow) - 1) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One clock: check outputs against the models at the falling edge, then commit transfers.
    task automatic step();
        bit a_acc, a_del, b_acc, b_del;
        int a_s, b_s;
        @(negedge clk);
        if (a_q.size() == 0) check_eq("a_idle", a_out_valid, 0);
        else if (a_t[0] > a_stall) check_eq("a_latency_exact", a_out_valid, (cyc - a_t[0] == A_L + 1));
        if (a_out_valid && a_q.size() > 0) begin
            check_eq("a_sum", a_out_sum, exp_sum(a_q[0], A_OW));
            check_eq("a_ovf", a_out_ovf, exp_ovf(a_q[0], A_OW));
            check_eq("a_latency_min", (cyc - a_t[0] >= A_L + 1), 1);
        end
        check_eq("a_in_ready", a_in_ready, (a_out_ready || a_q.size() < A_L + 1));
        check_eq("b_valid", b_out_valid, (b_q.size() > 0 && cyc - b_t[0] == B_L + 1));
        if (b_out_valid && b_q.size() > 0) begin
            check_eq("b_sum", b_out_sum, exp_sum(b_q[0], B_OW));
            check_eq("b_ovf", b_out_ovf, exp_ovf(b_q[0], B_OW));
        end
        check_eq("b_in_ready", b_in_ready, 1);
        a_acc = a_in_valid && a_in_ready;
        a_del = a_out_valid && a_out_ready;
        b_acc = b_in_valid && b_in_ready;
        b_del = b_out_valid && b_out_ready;
        a_s = vsum(64'(a_in_data), A_N, A_W);
        b_s = vsum(64'(b_in_data), B_N, B_W);
        if (!a_out_ready) a_stall = cyc;
        @(posedge clk);
        if (a_del && a_q.size() > 0) begin a_q.pop_front(); a_t.pop_front(); end
        if (b_del && b_q.size() > 0) begin b_q.pop_front(); b_t.pop_front(); end
        if (a_acc) begin a_q.push_back(a_s); a_t.push_back(cyc); end
        if (b_acc) begin b_q.push_back(b_s); b_t.push_back(cyc); end
        cyc++;
        #1;
    endtask

    task automatic set_a(input int v0, input int v1, input int v2);
        a_in_data = {A_W'(v2), A_W'(v1), A_W'(v0)};
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < A_N; k++)
            a_in_data[k*A_W +: A_W] = ($urandom_range(3) == 0) ? {A_W{1'b1}} : A_W'($urandom);
        for (int k = 0; k < B_N; k++)
            b_in_data[k*B_W +: B_W] = ($urandom_range(3) == 0) ? {B_W{1'b1}} : B_W'($urandom);
    endtask

    task automatic drain();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) if (a_q.size() > 0 || b_q.size() > 0) step();
        check_eq("drain_a", a_q.size(), 0);
        check_eq("drain_b", b_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
        #12;
        check_eq("rst_a_valid", a_out_valid, 0);
        check_eq("rst_a_sum", a_out_sum, 0);
        check_eq("rst_a_ovf", a_out_ovf, 0);
        check_eq("rst_a_in_ready", a_in_ready, 1);
        check_eq("rst_b_valid", b_out_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // T1: single vector, exact latency; B carries the all-ones 5x8 case.
        set_a(3, 8, 2); a_in_valid = 1'b1;
        b_in_data = {B_N*B_W{1'b1}}; b_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        step(); step();
        #3;
        check_eq("t1_valid", a_out_valid, 1);
        check_eq("t1_sum", a_out_sum, 13);
        step();
        #3;
        check_eq("t6_valid", b_out_valid, 1);
        check_eq("t6_sum", b_out_sum, exp_sum(1275, B_OW));
        check_eq("t6_ovf", b_out_ovf, exp_ovf(1275, B_OW));
        drain();

        // T2: back-to-back vectors including an all-zero one.
        a_in_valid = 1'b1;
        set_a(5, 1, 5); step();
        set_a(8, 5, 5); step();
        set_a(8, 5, 2); step();
        set_a(0, 0, 0); step();
        drain();

        // T3: one result held at the output while the pipe fills behind it.
        set_a(7, 9, 11); a_in_valid = 1'b1; step();
        a_in_valid = 1'b0; step(); step();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin rand_inputs(); step(); end
        #3;
        check_eq("t3_full", a_in_ready, 0);
        check_eq("t3_held_sum", a_out_sum, 27);
        drain();

        // T4: asynchronous reset while both pipes hold data.
        a_out_ready = 1'b0; a_in_valid = 1'b1; b_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin rand_inputs(); step(); end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t4_a_valid", a_out_valid, 0);
        check_eq("t4_a_sum", a_out_sum, 0);
        check_eq("t4_a_in_ready", a_in_ready, 1);
        check_eq("t4_b_valid", b_out_valid, 0);
        check_eq("t4_b_sum", b_out_sum, 0);
        a_q.delete(); a_t.delete(); b_q.delete(); b_t.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        cyc++;
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // T5: full-scale operands.
        set_a(1023, 1023, 1023); a_in_valid = 1'b1; step();
        a_in_valid = 1'b0; step(); step();
        #3;
        check_eq("t5_sum", a_out_sum, exp_sum(3069, A_OW));
        check_eq("t5_ovf", a_out_ovf, exp_ovf(3069, A_OW));
        drain();

        // Random traffic with random backpressure on A and random bubbles on both.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            a_in_valid = ($urandom_range(3) != 0);
            b_in_valid = ($urandom_range(3) != 0);
            a_out_ready = (i % 100 > 80) ? 1'b0 : ($urandom_range(2) != 0);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
